ci_cmd_sequencer: RTL



---
 rtl/ci_cmd_pkg.sv | 43 ++++
 rtl/ci_cmd_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ci_cmd_pkg.sv
// Shared constants for the CI command sequencer: opcodes, FSM state
// encodings, response phases, the status signature and small helpers.
package ci_cmd_pkg;

    localparam logic [7:0] OP_CLK_OFF   = 8'h00;
    localparam logic [7:0] OP_CLK_ON    = 8'h01;
    localparam logic [7:0] OP_RST_PULSE = 8'h02;
    localparam logic [7:0] OP_RST_REL   = 8'h03;
    localparam logic [7:0] OP_TX_SOC    = 8'h04;
    localparam logic [7:0] OP_TX_CTRL   = 8'h05;
    localparam logic [7:0] OP_RX_SOC    = 8'h06;
    localparam logic [7:0] OP_RX_HOLD   = 8'h07;
    localparam logic [7:0] OP_STEP      = 8'h08;
    localparam logic [7:0] OP_STATUS    = 8'h09;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ARG  = 3'd1;
    localparam logic [2:0] ST_RST_HOLD = 3'd2;
    localparam logic [2:0] ST_STEP     = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam logic [1:0] RP_WAIT  = 2'd0;
    localparam logic [1:0] RP_PULSE = 2'd1;
    localparam logic [1:0] RP_HOLD  = 2'd2;

    localparam logic [2:0] STATUS_SIG = 3'b101;

    function automatic logic [7:0] status_byte(
        input logic drop,
        input logic rx_sel,
        input logic tx_sel,
        input logic soc_rstn,
        input logic soc_clk_en
    );
        return {STATUS_SIG, drop, rx_sel, tx_sel, soc_rstn, soc_clk_en};
    endfunction

    // Step counter is loaded with N-1; an argument of 0 means 256 steps.
    function automatic logic [8:0] step_load(input logic [7:0] arg);
        return (arg == 8'd0) ? 9'd255 : ({1'b0, arg} - 9'd1);
    endfunction

endpackage

// File: rtl/ci_cmd_sequencer.sv
// Byte-command sequencer driving SoC clock gate, reset, step and serial muxes.
// Ports: clk/resetn; rx_valid/rx_data from UART rx; tx_busy/tx_en/tx_data to
// UART tx; soc_clk_en, soc_rstn, tx_sel, rx_sel control lines; busy = not IDLE.
module ci_cmd_sequencer
    import ci_cmd_pkg::*;
#(
    parameter int          RST_CYCLES     = 50,
    parameter int          TIMEOUT_CYCLES = 2700000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       soc_clk_en,
    output logic       soc_rstn,
    output logic       tx_sel,
    output logic       rx_sel,
    output logic       busy
);

    // Counters hold (count - 1) so the terminal value 0 marks the last cycle.
    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [1:0]  rphase;
    logic [7:0]  resp_byte;
    logic [15:0] rst_cnt;
    logic [8:0]  step_cnt;
    logic [31:0] to_cnt;
    logic        drop;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            rphase     <= RP_WAIT;
            resp_byte  <= 8'h00;
            rst_cnt    <= 16'd0;
            step_cnt   <= 9'd0;
            to_cnt     <= 32'd0;
            drop       <= 1'b0;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
            soc_clk_en <= 1'b1;
            soc_rstn   <= 1'b1;
            tx_sel     <= 1'b0;
            rx_sel     <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        // Default outcome; specific opcodes override below.
                        state     <= ST_RESP;
                        rphase    <= RP_WAIT;
                        resp_byte <= ACK_BYTE;
                        case (rx_data)
                            OP_CLK_OFF: soc_clk_en <= 1'b0;
                            OP_CLK_ON:  soc_clk_en <= 1'b1;
                            OP_RST_PULSE: begin
                                soc_rstn <= 1'b0;
                                rst_cnt  <= RST_LOAD;
                                state    <= ST_RST_HOLD;
                            end
                            OP_RST_REL: soc_rstn <= 1'b1;
                            OP_TX_SOC:  tx_sel <= 1'b0;
                            OP_TX_CTRL: tx_sel <= 1'b1;
                            OP_RX_SOC:  rx_sel <= 1'b0;
                            OP_RX_HOLD: rx_sel <= 1'b1;
                            OP_STEP: begin
                                to_cnt <= 32'd0;
                                state  <= ST_GET_ARG;
                            end
                            OP_STATUS: begin
                                resp_byte <= status_byte(drop, rx_sel, tx_sel,
                                                         soc_rstn, soc_clk_en);
                                drop      <= 1'b0;
                            end
                            default: resp_byte <= NAK_BYTE;
                        endcase
                    end
                end

                ST_GET_ARG: begin
                    if (rx_valid) begin
                        step_cnt   <= step_load(rx_data);
                        soc_clk_en <= 1'b1;
                        state      <= ST_STEP;
                    end else if (to_cnt == TO_LAST) begin
                        resp_byte <= NAK_BYTE;
                        rphase    <= RP_WAIT;
                        state     <= ST_RESP;
                    end else if (to_cnt != 32'hFFFF_FFFF) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end

                ST_RST_HOLD: begin
                    if (rx_valid) drop <= 1'b1;
                    if (rst_cnt == 16'd0) begin
                        soc_rstn  <= 1'b1;
                        resp_byte <= ACK_BYTE;
                        rphase    <= RP_WAIT;
                        state     <= ST_RESP;
                    end else begin
                        rst_cnt <= rst_cnt - 16'd1;
                    end
                end

                ST_STEP: begin
                    if (rx_valid) drop <= 1'b1;
                    if (step_cnt == 9'd0) begin
                        soc_clk_en <= 1'b0;
                        resp_byte  <= ACK_BYTE;
                        rphase     <= RP_WAIT;
                        state      <= ST_RESP;
                    end else begin
                        step_cnt <= step_cnt - 9'd1;
                    end
                end

                ST_RESP: begin
                    if (rx_valid) drop <= 1'b1;
                    case (rphase)
                        RP_WAIT: begin
                            if (!tx_busy) begin
                                tx_en   <= 1'b1;
                                tx_data <= resp_byte;
                                rphase  <= RP_PULSE;
                            end
                        end
                        // Extra cycle lets the transmitter raise tx_busy
                        // before a new command can start.
                        RP_PULSE: rphase <= RP_HOLD;
                        default: begin
                            rphase <= RP_WAIT;
                            state  <= ST_IDLE;
                        end
                    endcase
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
